// File: rtl/fm_fb_ctrl.sv
// fm_fb_ctrl: op1 self-feedback controller for the FM operator pipeline.
// Ports: clk, rst_n; req_* in, mod_* out; res_* writeback in; ram_* history RAM port; init_done.
module fm_fb_ctrl #(
    parameter int NUM_CH = 32,
    parameter int OUT_W  = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [4:0]         req_ch,
    input  logic [2:0]         req_fb,
    output logic               mod_valid,
    output logic [4:0]         mod_ch,
    output logic [9:0]         mod_out,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic [4:0]         res_ch,
    input  logic [OUT_W-1:0]   res_data,
    output logic [4:0]         ram_idx,
    output logic [2*OUT_W-1:0] ram_wrdata,
    output logic               ram_wren,
    input  logic [2*OUT_W-1:0] ram_rddata,
    output logic               init_done
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WB
    } state_t;

    localparam logic [4:0] LAST = 5'(NUM_CH - 1);

    state_t             state;
    logic [4:0]         cnt;
    logic [4:0]         wb_ch;
    logic [OUT_W-1:0]   wb_new;
    logic [OUT_W-1:0]   wb_old;

    logic [OUT_W-1:0]   h1;
    logic [OUT_W-1:0]   h0;
    logic signed [OUT_W:0] sum;
    logic [3:0]         sh;
    logic [9:0]         mod_next;

    assign h1 = ram_rddata[2*OUT_W-1:OUT_W];
    assign h0 = ram_rddata[OUT_W-1:0];

    // One extra bit holds the sum of two sign-extended samples exactly.
    assign sum = {h1[OUT_W-1], h1} + {h0[OUT_W-1], h0};
    assign sh  = 4'd9 - {1'b0, req_fb};

    // Low 10 bits of the arithmetic shift: phase wraps mod 1024.
    assign mod_next = (req_fb == 3'd0) ? 10'd0 : 10'(sum >>> sh);

    always_comb begin
        ram_idx    = '0;
        ram_wrdata = '0;
        ram_wren   = 1'b0;
        req_ready  = 1'b0;
        res_ready  = 1'b0;
        unique case (state)
            INIT: begin
                ram_idx  = cnt;
                ram_wren = 1'b1;
            end
            IDLE: begin
                // Writeback wins; a same-cycle request waits out the WB.
                if (res_valid) begin
                    res_ready = 1'b1;
                    ram_idx   = res_ch;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) ram_idx = req_ch;
                end
            end
            WB: begin
                ram_idx    = wb_ch;
                ram_wren   = 1'b1;
                ram_wrdata = {wb_new, wb_old};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            wb_ch     <= '0;
            wb_new    <= '0;
            wb_old    <= '0;
            mod_valid <= 1'b0;
            mod_ch    <= '0;
            mod_out   <= '0;
            init_done <= 1'b0;
        end else begin
            mod_valid <= 1'b0;
            unique case (state)
                INIT: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (res_valid) begin
                        // Newest sample becomes h1, previous h1 shifts to h0.
                        wb_ch  <= res_ch;
                        wb_new <= res_data;
                        wb_old <= h1;
                        state  <= WB;
                    end else if (req_valid) begin
                        mod_valid <= 1'b1;
                        mod_ch    <= req_ch;
                        mod_out   <= mod_next;
                    end
                end
                WB: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_fb_ctrl.sv
// tb_fm_fb_ctrl: directed-vector bench for fm_fb_ctrl.
// Models the async-read history RAM and checks the sweep, compute and hazards.
module tb_fm_fb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_ch;
    logic [2:0]  req_fb;
    logic        mod_valid;
    logic [4:0]  mod_ch;
    logic [9:0]  mod_out;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_ch;
    logic [12:0] res_data;
    logic [4:0]  ram_idx;
    logic [25:0] ram_wrdata;
    logic        ram_wren;
    logic [25:0] ram_rddata;
    logic        init_done;

    logic [25:0] mem [32];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fm_fb_ctrl #(.NUM_CH(32), .OUT_W(13)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ch     (req_ch),
        .req_fb     (req_fb),
        .mod_valid  (mod_valid),
        .mod_ch     (mod_ch),
        .mod_out    (mod_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ch     (res_ch),
        .res_data   (res_data),
        .ram_idx    (ram_idx),
        .ram_wrdata (ram_wrdata),
        .ram_wren   (ram_wren),
        .ram_rddata (ram_rddata),
        .init_done  (init_done)
    );

    assign ram_rddata = mem[ram_idx];

    always @(posedge clk) begin
        if (ram_wren) mem[ram_idx] <= ram_wrdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks n sweep cycles starting at idx 0; called at a negedge.
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            chk("init_wren", 32'(ram_wren), 32'd1);
            chk("init_idx", 32'(ram_idx), 32'(i));
            chk("init_wrdata", 32'(ram_wrdata), 32'd0);
            chk("init_req_rdy", 32'(req_ready), 32'd0);
            chk("init_res_rdy", 32'(res_ready), 32'd0);
            chk("init_done_lo", 32'(init_done), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic do_req(input logic [4:0] ch, input logic [2:0] fb,
                          input logic [9:0] exp);
        req_valid = 1'b1;
        req_ch    = ch;
        req_fb    = fb;
        #1;
        chk("req_ready", 32'(req_ready), 32'd1);
        chk("req_idx", 32'(ram_idx), 32'(ch));
        @(negedge clk);
        req_valid = 1'b0;
        chk("mod_valid", 32'(mod_valid), 32'd1);
        chk("mod_ch", 32'(mod_ch), 32'(ch));
        chk("mod_out", 32'(mod_out), 32'(exp));
        @(negedge clk);
        chk("mod_pulse", 32'(mod_valid), 32'd0);
    endtask

    task automatic do_res(input logic [4:0] ch, input logic [12:0] d);
        res_valid = 1'b1;
        res_ch    = ch;
        res_data  = d;
        #1;
        chk("res_ready", 32'(res_ready), 32'd1);
        chk("res_idx", 32'(ram_idx), 32'(ch));
        @(negedge clk);
        res_valid = 1'b0;
        chk("wb_wren", 32'(ram_wren), 32'd1);
        chk("wb_idx", 32'(ram_idx), 32'(ch));
        chk("wb_req_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 26'h3ffffff;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_ch    = '0;
        req_fb    = '0;
        res_valid = 1'b0;
        res_ch    = '0;
        res_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_mod_valid", 32'(mod_valid), 32'd0);
        chk("rst_mod_out", 32'(mod_out), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        rst_n = 1'b1;
        sweep(32);
        chk("init_done_hi", 32'(init_done), 32'd1);
        chk("idle_req_rdy", 32'(req_ready), 32'd1);
        chk("idle_wren", 32'(ram_wren), 32'd0);
        chk("idle_idx", 32'(ram_idx), 32'd0);
        chk("mem31_clear", 32'(mem[31]), 32'd0);
        chk("mem0_clear", 32'(mem[0]), 32'd0);

        do_req(5'd5, 3'd7, 10'h000);

        do_res(5'd3, 13'h0100);
        do_res(5'd3, 13'h0200);
        chk("mem3", 32'(mem[3]), 32'h0400100);
        do_req(5'd3, 3'd7, 10'h0C0);
        do_req(5'd3, 3'd0, 10'h000);
        do_req(5'd3, 3'd1, 10'h003);

        do_res(5'd9, 13'h1000);
        do_res(5'd9, 13'h1000);
        chk("mem9", 32'(mem[9]), 32'h2001000);
        do_req(5'd9, 3'd5, 10'h200);
        do_req(5'd9, 3'd7, 10'h000);
        do_req(5'd9, 3'd1, 10'h3E0);

        // Simultaneous result and request on channel 2.
        res_valid = 1'b1;
        res_ch    = 5'd2;
        res_data  = 13'h0400;
        req_valid = 1'b1;
        req_ch    = 5'd2;
        req_fb    = 3'd7;
        #1;
        chk("sim_c1_res_rdy", 32'(res_ready), 32'd1);
        chk("sim_c1_req_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        res_valid = 1'b0;
        chk("sim_c2_req_rdy", 32'(req_ready), 32'd0);
        chk("sim_c2_wren", 32'(ram_wren), 32'd1);
        chk("sim_c2_mod_v", 32'(mod_valid), 32'd0);
        @(negedge clk);
        chk("sim_c3_req_rdy", 32'(req_ready), 32'd1);
        chk("sim_c3_idx", 32'(ram_idx), 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        chk("sim_mod_valid", 32'(mod_valid), 32'd1);
        chk("sim_mod_ch", 32'(mod_ch), 32'd2);
        chk("sim_mod_out", 32'(mod_out), 32'h100);

        // Reset while in WB.
        res_valid = 1'b1;
        res_ch    = 5'd4;
        res_data  = 13'h0055;
        @(negedge clk);
        res_valid = 1'b0;
        chk("wb_before_rst", 32'(ram_wren), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wbrst_mod_out", 32'(mod_out), 32'd0);
        chk("wbrst_mod_ch", 32'(mod_ch), 32'd0);
        chk("wbrst_init_done", 32'(init_done), 32'd0);
        chk("wbrst_idx", 32'(ram_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(6);

        // Reset mid-INIT restarts the sweep from 0.
        rst_n = 1'b0;
        #1;
        chk("initrst_idx", 32'(ram_idx), 32'd0);
        chk("initrst_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(32);
        chk("init2_done_hi", 32'(init_done), 32'd1);
        chk("mem3_cleared", 32'(mem[3]), 32'd0);
        do_req(5'd3, 3'd7, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
